// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU with a valid/ready handshake on both sides.
// Single-cycle ops are registered at acceptance. MUL runs as a DW-step
// shift-add sequence. Results are held in DONE until the consumer takes them.
module mc_alu #(
    parameter int DW = 32,
    parameter int IW = 17,
    parameter int SW = $clog2(DW)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [4:0]    OP,
    input  logic [DW-1:0] VALA,
    input  logic [DW-1:0] VALB,
    input  logic [IW-1:0] IMM,
    input  logic [2:0]    COND,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] RESULT,
    output logic          TAKEN,
    output logic          OVF,
    output logic          BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_NEG  = 5'd2,
        OP_NOT  = 5'd3,
        OP_AND  = 5'd4,
        OP_OR   = 5'd5,
        OP_XOR  = 5'd6,
        OP_ADDI = 5'd7,
        OP_ANDI = 5'd8,
        OP_ORI  = 5'd9,
        OP_MOVI = 5'd10,
        OP_LSR  = 5'd11,
        OP_ASR  = 5'd12,
        OP_SHL  = 5'd13,
        OP_ROR  = 5'd14,
        OP_BR   = 5'd15,
        OP_MUL  = 5'd16
    } op_t;

    state_t        state_q;
    state_t        state_d;

    logic          accept;
    logic          is_mul;
    logic          mul_last;

    logic [DW-1:0] mcand_q;
    logic [DW-1:0] mplier_q;
    logic [DW-1:0] acc_q;
    logic [DW-1:0] acc_next;
    logic [SW:0]   iter_q;

    logic signed [IW-1:0] imm_s;
    logic [DW-1:0] simm;
    logic [SW-1:0] shamt;
    logic [SW:0]   rot_left;
    logic [DW-1:0] sum_ab;
    logic [DW-1:0] diff_ab;
    logic [DW-1:0] sum_bi;

    logic [DW-1:0] alu_res;
    logic          alu_taken;
    logic          alu_ovf;

    assign IN_READY  = (state_q == IDLE) || ((state_q == DONE) && OUT_READY);
    assign OUT_VALID = (state_q == DONE);
    assign BUSY      = (state_q == MUL);

    assign accept    = IN_VALID && IN_READY;
    assign is_mul    = (OP == OP_MUL);
    assign mul_last  = (state_q == MUL) && (iter_q == (SW+1)'(DW - 1));
    assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign imm_s     = IMM;
    assign simm      = DW'(imm_s);
    assign shamt     = IMM[SW-1:0];
    // Left half of the rotate; a zero amount shifts by DW, which yields 0.
    assign rot_left  = (SW+1)'(DW) - {1'b0, shamt};
    assign sum_ab    = VALA + VALB;
    assign diff_ab   = VALA - VALB;
    assign sum_bi    = VALB + simm;

    // Single-cycle result, branch decision and overflow from the presented operands
    always_comb begin
        alu_res   = '0;
        alu_taken = 1'b0;
        alu_ovf   = 1'b0;
        case (OP)
            OP_ADD: begin
                alu_res = sum_ab;
                alu_ovf = (VALA[DW-1] == VALB[DW-1]) && (sum_ab[DW-1] != VALA[DW-1]);
            end
            OP_SUB: begin
                alu_res = diff_ab;
                alu_ovf = (VALA[DW-1] != VALB[DW-1]) && (diff_ab[DW-1] != VALA[DW-1]);
            end
            OP_NEG:  alu_res = '0 - VALB;
            OP_NOT:  alu_res = ~VALB;
            OP_AND:  alu_res = VALA & VALB;
            OP_OR:   alu_res = VALA | VALB;
            OP_XOR:  alu_res = VALA ^ VALB;
            OP_ADDI: begin
                alu_res = sum_bi;
                alu_ovf = (VALB[DW-1] == simm[DW-1]) && (sum_bi[DW-1] != VALB[DW-1]);
            end
            OP_ANDI: alu_res = VALB & simm;
            OP_ORI:  alu_res = VALB | simm;
            OP_MOVI: alu_res = simm;
            OP_LSR:  alu_res = VALB >> shamt;
            OP_ASR:  alu_res = $unsigned($signed(VALB) >>> shamt);
            OP_SHL:  alu_res = VALB << shamt;
            OP_ROR:  alu_res = (VALB >> shamt) | (VALB << rot_left);
            OP_BR: begin
                alu_res = VALA;
                case (COND)
                    3'd1:    alu_taken = 1'b1;
                    3'd2:    alu_taken = (VALB == '0);
                    3'd3:    alu_taken = (VALB != '0);
                    3'd4:    alu_taken = !VALB[DW-1];
                    3'd5:    alu_taken = VALB[DW-1];
                    default: alu_taken = 1'b0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = is_mul ? MUL : DONE;
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_d = is_mul ? MUL : DONE;
                end else if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result registers and the shift-add multiplier datapath
    always_ff @(posedge CLK) begin
        if (RST) begin
            RESULT   <= '0;
            TAKEN    <= 1'b0;
            OVF      <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            iter_q   <= '0;
        end else begin
            if (accept && !is_mul) begin
                RESULT <= alu_res;
                TAKEN  <= alu_taken;
                OVF    <= alu_ovf;
            end
            if (accept && is_mul) begin
                mcand_q  <= VALA;
                mplier_q <= VALB;
                acc_q    <= '0;
                iter_q   <= '0;
            end
            if (state_q == MUL) begin
                acc_q    <= acc_next;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                iter_q   <= iter_q + (SW+1)'(1);
                if (mul_last) begin
                    RESULT <= acc_next;
                    TAKEN  <= 1'b0;
                    OVF    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter DW, default 32, SHALL set the datapath width in bits (DW >= 8, power of two).
REQ-002 Parameter IW, default 17, SHALL set the immediate width in bits (IW <= DW).
REQ-003 Parameter SW, default $clog2(DW), SHALL set the shift-amount width.
REQ-004 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 RST  in  1  SHALL be the reset, synchronous and active-high.
REQ-006 IN_VALID  in  1  SHALL indicate an operation is presented.
REQ-007 IN_READY  out  1  SHALL indicate the unit accepts an operation this cycle.
REQ-008 OP  in  5  SHALL select the operation.
REQ-009 VALA, VALB  in  DW each  SHALL be the source operands.
REQ-010 IMM  in  IW  SHALL be the immediate field.
REQ-011 COND  in  3  SHALL be the branch condition code.
REQ-012 OUT_VALID  out  1  SHALL indicate RESULT, TAKEN and OVF are valid.
REQ-013 OUT_READY  in  1  SHALL indicate the consumer takes the result this cycle.
REQ-014 RESULT  out  DW  SHALL be the registered result.
REQ-015 TAKEN  out  1  SHALL be the registered branch-taken flag.
REQ-016 OVF  out  1  SHALL be the registered signed-overflow flag.
REQ-017 BUSY  out  1  SHALL be high while in state MUL.

Function
REQ-018 An operation SHALL be accepted on a cycle where IN_VALID && IN_READY; operands are captured that edge.
REQ-019 The FSM SHALL have states IDLE, MUL and DONE; IN_READY = (IDLE) || (DONE && OUT_READY).
REQ-020 Transitions: IDLE/DONE -> accept of a non-MUL op -> DONE; accept of MUL -> MUL; DONE with OUT_READY and no accept -> IDLE; DONE without OUT_READY -> DONE; MUL -> DONE after DW iterations.
REQ-021 Non-MUL latency SHALL be 1 cycle: OUT_VALID high the cycle after acceptance, with back-to-back acceptance giving one result per cycle.
REQ-022 MUL latency SHALL be DW+1 cycles from acceptance to OUT_VALID; one shift-add iteration per cycle, counter width SW+1.
REQ-023 While OUT_VALID && !OUT_READY, RESULT, TAKEN and OVF SHALL hold stable.
REQ-024 The immediate SHALL be sign-extended from bit IW-1 to DW bits (SIMM); the shift amount SHALL be IMM[SW-1:0].
REQ-025 OP codes: 0 ADD A+B; 1 SUB A-B; 2 NEG -B; 3 NOT ~B; 4 AND; 5 OR; 6 XOR; 7 ADDI B+SIMM; 8 ANDI B&SIMM; 9 ORI B|SIMM; 10 MOVI SIMM; 11 LSR B logical right; 12 ASR B arithmetic right; 13 SHL B left; 14 ROR B rotate right; 15 BR; 16 MUL low DW bits of A*B; 17-31 RESULT 0.
REQ-026 All arithmetic SHALL be modulo 2^DW; MUL low DW bits are sign-agnostic.
REQ-027 OVF SHALL be set only for ADD, SUB, ADDI on two's-complement signed overflow, else 0.
REQ-028 For BR, RESULT SHALL be VALA (target) and TAKEN per COND on VALB: 0 never, 1 always, 2 VALB==0, 3 VALB!=0, 4 VALB>=0 signed, 5 VALB<0 signed, 6-7 never; TAKEN SHALL be 0 for non-BR ops.
REQ-029 Shift amount 0 SHALL return VALB unchanged for all shift/rotate ops.
REQ-030 IN_READY SHALL be 0 in MUL; IN_VALID during MUL SHALL be ignored, not queued.

Reset
REQ-031 RST high at a rising edge SHALL force state IDLE, OUT_VALID 0, RESULT 0, TAKEN 0, OVF 0, BUSY 0, iteration counter 0.
REQ-032 RST during MUL or DONE SHALL discard the in-flight operation; no result SHALL appear after reset.
REQ-033 The cycle after RST deasserts, IN_READY SHALL be 1.

Verification (DW=32, IW=17)
REQ-034 ADD A=0x7FFFFFFF B=1, OUT_READY=1 -> next cycle OUT_VALID=1, RESULT=0x80000000, OVF=1.
REQ-035 ADDI B=5 IMM=0x1FFFF -> RESULT=4; MOVI IMM=0x10000 -> RESULT=0xFFFF0000.
REQ-036 MUL A=0xFFFFFFFF B=3 -> BUSY for 32 cycles, IN_READY=0, OUT_VALID at cycle 33, RESULT=0xFFFFFFFD.
REQ-037 BR COND=5 A=0x100 B=0x80000000 -> RESULT=0x100, TAKEN=1; COND=4 same operands -> TAKEN=0.
REQ-038 Two back-to-back ops (ASR B=0x80000000 IMM=4, then ROR B=0x1 IMM=1) with OUT_READY=0 for 3 cycles -> first RESULT=0xF8000000 held, second accepted only on the cycle OUT_READY rises, then RESULT=0x80000000.
REQ-039 RST asserted at MUL iteration 10 -> next cycle OUT_VALID=0, RESULT=0, BUSY=0, IN_READY=1; no stale result thereafter.
